mips_fetch: RTL and testbench

MIPS_FETCH -- requirements
Module: mips_fetch

---
 rtl/mips_fetch.sv | 152 +++++++++++++++
 tb/tb_mips_fetch.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch.sv
`timescale 1ns/1ps
// mips_fetch: single-outstanding instruction fetch with a 2-entry prefetch FIFO.
// Define MIPS_FETCH_PERF_EN to add the perf_fetched / perf_flushed counters.
module mips_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc,
   output logic [31:0] pc_out
`ifdef MIPS_FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_flushed
`endif
);

   localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q;
   logic [31:0] addr_q;
   logic [31:0] fdata_q [2];
   logic [31:0] fpc_q [2];
   logic        rd_q, wr_q;
   logic [1:0]  cnt_q;
   logic        issue, enq, deq, has_space;

   assign inst_valid = (cnt_q != 2'd0);
   assign deq        = inst_valid && inst_ready && !redirect;
   // A same-cycle dequeue frees a slot, so a full FIFO can still issue.
   assign has_space  = (cnt_q < DEPTH) || deq;

   assign imem_req  = issue;
   assign imem_addr = issue ? pc_q : addr_q;
   assign pc_out    = pc_q;
   assign inst_out  = fdata_q[rd_q];
   assign inst_pc   = fpc_q[rd_q];

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // FSM next state; a redirect that coincides with the response
   // consumes it, so nothing is left to discard
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (!redirect && has_space) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (redirect)
               state_d = imem_rvalid ? S_IDLE : S_DISCARD;
            else if (imem_rvalid)
               state_d = S_IDLE;
         end
         S_DISCARD: begin
            if (imem_rvalid) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: request issue and FIFO write strobe
   always_comb begin
      issue = 1'b0;
      enq   = 1'b0;
      unique case (state_q)
         S_IDLE:  issue = !reset && !redirect && has_space;
         S_WAIT:  enq   = imem_rvalid && !redirect;
         default: ;
      endcase
   end

   // Fetch PC and the held address of the last request
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q   <= RESET_PC;
         addr_q <= RESET_PC;
      end else if (redirect) begin
         pc_q   <= redirect_pc & 32'hFFFF_FFFC;
      end else if (issue) begin
         pc_q   <= pc_q + 32'd4;
         addr_q <= pc_q;
      end
   end

   // Prefetch FIFO; redirect flushes it ahead of any write or read
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= 2'd0;
         rd_q  <= 1'b0;
         wr_q  <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            fdata_q[i] <= 32'd0;
            fpc_q[i]   <= 32'd0;
         end
      end else if (redirect) begin
         cnt_q <= 2'd0;
         rd_q  <= 1'b0;
         wr_q  <= 1'b0;
      end else begin
         if (enq) begin
            fdata_q[wr_q] <= imem_rdata;
            fpc_q[wr_q]   <= addr_q;
            wr_q          <= ~wr_q;
         end
         if (deq) rd_q <= ~rd_q;
         cnt_q <= cnt_q + {1'b0, enq} - {1'b0, deq};
      end
   end

`ifdef MIPS_FETCH_PERF_EN
   logic [31:0] fetched_q, flushed_q;
   logic        flushing;

   assign flushing     = redirect && (inst_valid || state_q == S_WAIT);
   assign perf_fetched = fetched_q;
   assign perf_flushed = flushed_q;

   // Dequeue and flushing-redirect counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetched_q <= 32'd0;
         flushed_q <= 32'd0;
      end else begin
         if (deq)      fetched_q <= fetched_q + 32'd1;
         if (flushing) flushed_q <= flushed_q + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mips_fetch.sv
`timescale 1ns/1ps
// tb_mips_fetch: random fetch traffic against an expected-PC-stream scoreboard.
module tb_mips_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst_out, inst_pc, pc_out;
`ifdef MIPS_FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_flushed;
   logic        live = 1'b0;
   int          flush_cnt = 0;
   int          deq_rst = 0;
`endif

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_next = 32'd0;
   logic [31:0] mon_e;
   int          req_count = 0;
   logic [31:0] last_req = 32'd0;
   logic        req_seen = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic        mem_busy = 1'b0;
   logic [31:0] mem_a = 32'd0;
   int          mem_dly = 0;
   int          lat_lo = 0;
   int          lat_hi = 0;
   logic        late_rsp = 1'b0;
   logic        hold_prev = 1'b0;
   logic [31:0] prev_out, prev_pc;
   int          n_deq = 0;
   int          base;

   mips_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst_out(inst_out), .inst_pc(inst_pc), .pc_out(pc_out)
`ifdef MIPS_FETCH_PERF_EN
      , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   // New expected program stream starting at a word-aligned pc
   task automatic restart(input logic [31:0] pc);
      exp_q.delete();
      exp_next = pc & 32'hFFFF_FFFC;
   endtask

   task automatic reset_checks();
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", imem_addr, RST_PC);
      chk("rst_pc_out", pc_out, RST_PC);
      chk("rst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst", inst_out, 32'd0);
      chk("rst_inst_pc", inst_pc, 32'd0);
   endtask

   // Called at posedge+1; redirect held for exactly one cycle
   task automatic do_redirect(input logic [31:0] t);
      redirect    = 1'b1;
      redirect_pc = t;
      restart(t);
      @(posedge clk); #1;
      redirect = 1'b0;
   endtask

   task automatic wait_reqs(input int n);
      int t = 0;
      while (req_count < n && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 200) begin
         checks++;
         errors++;
         $display("FAIL req_timeout: got %0d reqs, want %0d", req_count, n);
      end
   endtask

   // Instruction memory: one outstanding read, latency lat_lo..lat_hi
   initial forever begin
      @(posedge clk); #2;
      while (exp_q.size() < 8) begin
         exp_q.push_back(exp_next);
         exp_next += 32'd4;
      end
      if (reset) begin
         mem_busy    = 1'b0;
         req_seen    = 1'b0;
         imem_rvalid = 1'b0;
      end else if (late_rsp) begin
         imem_rvalid = 1'b1;
         imem_rdata  = 32'hDEAD_BEEF;
         late_rsp    = 1'b0;
      end else begin
         if (req_seen) begin
            mem_busy = 1'b1;
            mem_a    = req_addr;
            mem_dly  = int'($urandom_range(lat_hi, lat_lo));
            req_seen = 1'b0;
         end
         if (mem_busy && mem_dly == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_at(mem_a);
            mem_busy    = 1'b0;
         end else begin
            imem_rvalid = 1'b0;
            if (mem_busy) mem_dly--;
         end
      end
   end

   // Monitor: scoreboard pops on dequeue, head stability, outstanding limit
   always @(negedge clk) begin
      if (!reset) begin
         if (hold_prev) begin
            chk("hold_valid", 32'(inst_valid), 32'd1);
            chk("hold_pc", inst_pc, prev_pc);
            chk("hold_inst", inst_out, prev_out);
         end
         hold_prev = inst_valid && !inst_ready && !redirect;
         prev_pc   = inst_pc;
         prev_out  = inst_out;
         if (inst_valid && inst_ready && !redirect) begin
            n_deq++;
`ifdef MIPS_FETCH_PERF_EN
            deq_rst++;
`endif
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL deq_unexpected: got pc %h, want none", inst_pc);
            end else begin
               mon_e = exp_q.pop_front();
               chk("deq_pc", inst_pc, mon_e);
               chk("deq_inst", inst_out, word_at(mon_e));
            end
         end
`ifdef MIPS_FETCH_PERF_EN
         if (redirect && (inst_valid || live)) flush_cnt++;
         if (imem_req) live = 1'b1;
         else if (redirect || imem_rvalid) live = 1'b0;
`endif
         if (imem_req) begin
            chk("one_outstanding", 32'(mem_busy), 32'd0);
            req_count++;
            last_req = imem_addr;
            req_seen = 1'b1;
            req_addr = imem_addr;
         end
      end else begin
         hold_prev = 1'b0;
`ifdef MIPS_FETCH_PERF_EN
         live      = 1'b0;
         flush_cnt = 0;
         deq_rst   = 0;
`endif
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_checks();
      restart(RST_PC);
      inst_ready = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk); #1;
      chk("first_req_cnt", 32'(req_count), 32'd1);
      chk("first_req_addr", last_req, RST_PC);

      // Sequential fetch with one-cycle memory
      wait_reqs(4);
      chk("addr_4th", last_req, RST_PC + 32'hC);
      chk("pc_out_4", pc_out, RST_PC + 32'h10);

      // Back-pressure: two buffered, no third request
      inst_ready = 1'b0;
      do_redirect(32'h0);
      base = req_count;
      repeat (8) begin @(posedge clk); #1; end
      chk("two_reqs", 32'(req_count - base), 32'd2);
      base = req_count;
      repeat (6) begin @(posedge clk); #1; end
      chk("no_third_req", 32'(req_count), 32'(base));
      chk("full_valid", 32'(inst_valid), 32'd1);
      chk("full_head_pc", inst_pc, 32'h0);
      inst_ready = 1'b1;
      @(negedge clk); #1;
      chk("req_with_deq", 32'(req_count), 32'(base + 1));
      chk("req_with_deq_addr", last_req, 32'h8);

      // Redirect while a slow request is outstanding
      lat_lo = 3;
      lat_hi = 3;
      base = req_count;
      wait_reqs(base + 1);
      do_redirect(32'h0000_0103);
      base = req_count;
      wait_reqs(base + 1);
      chk("redir_addr", last_req, 32'h0000_0100);
      chk("redir_empty", 32'(inst_valid), 32'd0);

      // Redirect coinciding with a response, one entry buffered
      lat_lo = 0;
      lat_hi = 0;
      inst_ready = 1'b0;
      do_redirect(32'h200);
      base = req_count;
      wait_reqs(base + 2);
      do_redirect(32'h300);
      @(negedge clk); #1;
      chk("coinc_empty", 32'(inst_valid), 32'd0);
      chk("coinc_req", 32'(imem_req), 32'd1);
      chk("coinc_addr", imem_addr, 32'h300);

      // Address wrap at the top of memory
      @(posedge clk); #1;
      inst_ready = 1'b1;
      do_redirect(32'hFFFF_FFFE);
      base = req_count;
      wait_reqs(base + 1);
      chk("wrap_first", last_req, 32'hFFFF_FFFC);
      wait_reqs(base + 2);
      chk("wrap_second", last_req, 32'h0);

      // Random traffic with one mid-run reset
      lat_hi = 3;
      for (int i = 0; i < 1500; i++) begin
         @(posedge clk); #1;
         inst_ready = ($urandom_range(9) < 7);
         if (i == 700) begin
            redirect = 1'b0;
            reset    = 1'b1;
            restart(RST_PC);
            @(negedge clk);
            reset_checks();
            late_rsp = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
         end else if ($urandom_range(19) == 0) begin
            redirect    = 1'b1;
            redirect_pc = $urandom;
            restart(redirect_pc);
         end else begin
            redirect = 1'b0;
         end
      end
      redirect   = 1'b0;
      inst_ready = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("progress", 32'(n_deq >= 200), 32'd1);
`ifdef MIPS_FETCH_PERF_EN
      chk("perf_fetched", perf_fetched, 32'(deq_rst));
      chk("perf_flushed", perf_flushed, 32'(flush_cnt));
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
